// File: rtl/mandel_pixel_scheduler.sv
// mandel_pixel_scheduler: walks one frame in raster order and, for each pixel,
// hands a coordinate to the iteration engine. It then classifies the returned
// iteration count and offers the pixel downstream over a valid/ready handshake.
// Optional feature macro: MANDEL_SCHED_ABORT_EN adds an 'abort' input that
// drops any frame in progress back to IDLE.
module mandel_pixel_scheduler #(
    parameter int H_RES = 320,
    parameter int V_RES = 240,
    parameter int XW    = $clog2(H_RES),
    parameter int YW    = $clog2(V_RES)
) (
    input  logic          clk,
    input  logic          nrst,
`ifdef MANDEL_SCHED_ABORT_EN
    input  logic          abort,
`endif
    input  logic          frame_start,
    input  logic [7:0]    max_iter,
    output logic          calc_start,
    output logic [XW-1:0] calc_x,
    output logic [YW-1:0] calc_y,
    input  logic          calc_done,
    input  logic [7:0]    calc_iter,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [7:0]    pix_iter,
    output logic          pix_ismandelbrot,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [7:0]    limit;
    logic          handshake;
    logic          last_pix;
    logic          abort_hit;

`ifdef MANDEL_SCHED_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign handshake = (state == S_OUTPUT) && pix_ready;
    assign last_pix  = (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and state-decoded outputs; abort overrides every other transition
    always_comb begin
        state_nxt  = state;
        calc_start = 1'b0;
        pix_valid  = 1'b0;
        frame_done = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:   if (frame_start) state_nxt = S_ISSUE;
            S_ISSUE: begin
                calc_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT:   if (calc_done) state_nxt = S_OUTPUT;
            S_OUTPUT: begin
                pix_valid = 1'b1;
                if (pix_ready) state_nxt = last_pix ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
        if (abort_hit) state_nxt = S_IDLE;
    end

    // Raster counters and the iteration limit latched at frame start
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            x     <= '0;
            y     <= '0;
            limit <= '0;
        end else if (abort_hit) begin
            x <= '0;
            y <= '0;
        end else begin
            case (state)
                S_IDLE: if (frame_start) begin
                    x     <= '0;
                    y     <= '0;
                    limit <= max_iter;
                end
                S_OUTPUT: if (handshake) begin
                    if (last_pix) begin
                        x <= '0;
                        y <= '0;
                    end else if (x == XW'(H_RES - 1)) begin
                        x <= '0;
                        y <= y + YW'(1);
                    end else begin
                        x <= x + XW'(1);
                    end
                end
                S_DONE: begin
                    x <= '0;
                    y <= '0;
                end
                default: ;
            endcase
        end
    end

    // Capture the engine result only while waiting for it
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pix_iter         <= '0;
            pix_ismandelbrot <= 1'b0;
        end else if (state == S_WAIT && calc_done && !abort_hit) begin
            pix_iter         <= calc_iter;
            pix_ismandelbrot <= (calc_iter >= limit);
        end
    end

    // Counters hold the in-flight pixel from ISSUE through OUTPUT
    assign calc_x = x;
    assign calc_y = y;
    assign pix_x  = x;
    assign pix_y  = y;

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Directed bench for mandel_pixel_scheduler at H_RES=4, V_RES=2, with a
// behavioural engine answering 5 cycles after each calc_start.
module tb_mandel_pixel_scheduler;

    logic       clk = 1'b0;
    logic       nrst;
    logic       frame_start;
    logic [7:0] max_iter;
    logic       calc_start;
    logic [1:0] calc_x;
    logic [0:0] calc_y;
    logic       calc_done;
    logic [7:0] calc_iter;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_iter;
    logic       pix_ismandelbrot;
    logic [1:0] pix_x;
    logic [0:0] pix_y;
    logic       busy;
    logic       frame_done;
`ifdef MANDEL_SCHED_ABORT_EN
    logic       abort;
`endif

    int checks = 0;
    int errors = 0;

    // Engine behaviour: 0 -> x+y, 1 -> table by raster index, 2 -> constant 42
    int iter_mode = 0;
    int tbl [0:7] = '{9, 10, 255, 0, 0, 0, 0, 0};
    int stray_req = 0;
    int stray_ack = 0;

    // Handshake log filled by capture_frame
    int got_x [0:7];
    int got_y [0:7];
    int got_iter [0:7];
    int got_ism [0:7];
    int n_hs, n_done;
    bit timed_out;

    mandel_pixel_scheduler #(.H_RES(4), .V_RES(2)) dut (
        .clk(clk),
        .nrst(nrst),
`ifdef MANDEL_SCHED_ABORT_EN
        .abort(abort),
`endif
        .frame_start(frame_start),
        .max_iter(max_iter),
        .calc_start(calc_start),
        .calc_x(calc_x),
        .calc_y(calc_y),
        .calc_done(calc_done),
        .calc_iter(calc_iter),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_iter(pix_iter),
        .pix_ismandelbrot(pix_ismandelbrot),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Engine model; also injects a stray calc_done on request
    initial begin
        int ex, ey, v;
        calc_done = 1'b0;
        calc_iter = 8'd0;
        forever begin
            @(negedge clk);
            if (calc_start) begin
                ex = int'(calc_x);
                ey = int'(calc_y);
                case (iter_mode)
                    0:       v = ex + ey;
                    1:       v = tbl[ey * 4 + ex];
                    default: v = 42;
                endcase
                repeat (4) @(negedge clk);
                calc_done = 1'b1;
                calc_iter = 8'(v);
                @(negedge clk);
                calc_done = 1'b0;
            end else if (stray_req != stray_ack) begin
                calc_done = 1'b1;
                calc_iter = 8'd77;
                @(negedge clk);
                calc_done = 1'b0;
                stray_ack++;
            end
        end
    end

    task automatic start_frame(input int mi);
        @(negedge clk);
        frame_start = 1'b1;
        max_iter    = 8'(mi);
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // Sample at the current negedge first, then step; stops 3 cycles after frame_done
    task automatic capture_frame();
        int post;
        n_hs = 0; n_done = 0; timed_out = 1'b0; post = -1;
        for (int c = 0; c < 400; c++) begin
            if (pix_valid && pix_ready) begin
                if (n_hs < 8) begin
                    got_x[n_hs]    = int'(pix_x);
                    got_y[n_hs]    = int'(pix_y);
                    got_iter[n_hs] = int'(pix_iter);
                    got_ism[n_hs]  = int'(pix_ismandelbrot);
                end
                n_hs++;
            end
            if (frame_done) begin
                n_done++;
                if (post < 0) post = 0;
            end
            if (post >= 0) begin
                post++;
                if (post > 3) break;
            end
            @(negedge clk);
        end
        if (post < 0) timed_out = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        for (int c = 0; c < 50 && !pix_valid; c++) @(negedge clk);
        checks++;
        if (pix_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: pix_valid timeout got %b want 1", name, pix_valid);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0; frame_start = 1'b0; max_iter = 8'd0; pix_ready = 1'b0;
`ifdef MANDEL_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, calc_start, pix_valid, frame_done, pix_ismandelbrot} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {busy, calc_start, pix_valid, frame_done, pix_ismandelbrot});
        end
        checks++;
        if ({pix_iter, pix_x, pix_y, calc_x, calc_y} !== 14'd0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {pix_iter, pix_x, pix_y, calc_x, calc_y});
        end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_frame();
        iter_mode = 0;
        pix_ready = 1'b1;
        start_frame(10);
        capture_frame();
        checks++;
        if (timed_out || n_hs !== 8 || n_done !== 1) begin
            errors++;
            $display("FAIL full_counts: hs=%0d done=%0d to=%0d want hs=8 done=1 to=0",
                     n_hs, n_done, timed_out);
        end
        for (int i = 0; i < 8 && i < n_hs; i++) begin
            checks++;
            if (got_x[i] !== i % 4 || got_y[i] !== i / 4 || got_iter[i] !== i % 4 + i / 4
                || got_ism[i] !== 0) begin
                errors++;
                $display("FAIL full_pix%0d: got (%0d,%0d) it=%0d ism=%0d want (%0d,%0d) it=%0d ism=0",
                         i, got_x[i], got_y[i], got_iter[i], got_ism[i], i % 4, i / 4, i % 4 + i / 4);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL full_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_classify();
        int want_ism [0:2] = '{0, 1, 1};
        int want_it  [0:2] = '{9, 10, 255};
        iter_mode = 1;
        pix_ready = 1'b1;
        start_frame(10);
        capture_frame();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (n_hs < 3 || got_ism[i] !== want_ism[i] || got_iter[i] !== want_it[i]) begin
                errors++;
                $display("FAIL classify%0d: got it=%0d ism=%0d want it=%0d ism=%0d",
                         i, got_iter[i], got_ism[i], want_it[i], want_ism[i]);
            end
        end
        iter_mode = 2;
        start_frame(0);
        capture_frame();
        checks++;
        if (n_hs !== 8) begin
            errors++;
            $display("FAIL limit0_count: got %0d want 8", n_hs);
        end
        for (int i = 0; i < 8 && i < n_hs; i++) begin
            checks++;
            if (got_ism[i] !== 1 || got_iter[i] !== 42) begin
                errors++;
                $display("FAIL limit0_pix%0d: got ism=%0d it=%0d want ism=1 it=42",
                         i, got_ism[i], got_iter[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        iter_mode = 0;
        pix_ready = 1'b0;
        start_frame(10);
        wait_valid("bp_wait");
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (pix_valid !== 1'b1 || calc_start !== 1'b0 || pix_iter !== 8'd0
                || pix_ismandelbrot !== 1'b0 || pix_x !== 2'd0 || pix_y !== 1'd0) begin
                errors++;
                $display("FAIL bp_hold%0d: v=%b cs=%b it=%0d ism=%b x=%0d y=%0d want v=1 cs=0 it=0 ism=0 x=0 y=0",
                         c, pix_valid, calc_start, pix_iter, pix_ismandelbrot, pix_x, pix_y);
            end
            @(negedge clk);
        end
        pix_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (pix_valid !== 1'b0 || calc_start !== 1'b1 || calc_x !== 2'd1 || calc_y !== 1'd0) begin
            errors++;
            $display("FAIL bp_release: v=%b cs=%b cx=%0d cy=%0d want v=0 cs=1 cx=1 cy=0",
                     pix_valid, calc_start, calc_x, calc_y);
        end
        capture_frame();
        checks++;
        if (n_hs !== 7 || n_done !== 1 || got_x[0] !== 1 || got_y[0] !== 0) begin
            errors++;
            $display("FAIL bp_rest: hs=%0d done=%0d first=(%0d,%0d) want hs=7 done=1 first=(1,0)",
                     n_hs, n_done, got_x[0], got_y[0]);
        end
    endtask

    task automatic test_ignored();
        iter_mode = 0;
        pix_ready = 1'b0;
        start_frame(10);
        @(negedge clk);
        frame_start = 1'b1;
        max_iter    = 8'd3;
        @(negedge clk);
        frame_start = 1'b0;
        wait_valid("ign_wait");
        stray_req++;
        repeat (4) @(negedge clk);
        checks++;
        if (pix_valid !== 1'b1 || pix_iter !== 8'd0 || pix_x !== 2'd0) begin
            errors++;
            $display("FAIL ign_stray: v=%b it=%0d x=%0d want v=1 it=0 x=0",
                     pix_valid, pix_iter, pix_x);
        end
        pix_ready = 1'b1;
        capture_frame();
        checks++;
        if (n_hs !== 8 || n_done !== 1) begin
            errors++;
            $display("FAIL ign_counts: hs=%0d done=%0d want hs=8 done=1", n_hs, n_done);
        end
        for (int i = 0; i < 8 && i < n_hs; i++) begin
            checks++;
            if (got_x[i] !== i % 4 || got_y[i] !== i / 4 || got_ism[i] !== 0) begin
                errors++;
                $display("FAIL ign_pix%0d: got (%0d,%0d) ism=%0d want (%0d,%0d) ism=0",
                         i, got_x[i], got_y[i], got_ism[i], i % 4, i / 4);
            end
        end
    endtask

    task automatic test_mid_reset();
        int c;
        iter_mode = 0;
        pix_ready = 1'b1;
        start_frame(10);
        for (c = 0; c < 200 && !(calc_start && calc_x == 2'd2 && calc_y == 1'd1); c++)
            @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || pix_iter !== 8'd2) begin
            errors++;
            $display("FAIL rst_pre: busy=%b it=%0d want busy=1 it=2", busy, pix_iter);
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({busy, calc_start, pix_valid, frame_done, pix_ismandelbrot, pix_iter,
             pix_x, pix_y, calc_x, calc_y} !== 19'd0) begin
            errors++;
            $display("FAIL rst_async: got %h want 0", {busy, calc_start, pix_valid, frame_done,
                     pix_ismandelbrot, pix_iter, pix_x, pix_y, calc_x, calc_y});
        end
        @(negedge clk);
        nrst = 1'b1;
        repeat (8) @(negedge clk);
        start_frame(10);
        capture_frame();
        checks++;
        if (n_hs !== 8 || got_x[0] !== 0 || got_y[0] !== 0 || n_done !== 1) begin
            errors++;
            $display("FAIL rst_restart: hs=%0d first=(%0d,%0d) done=%0d want hs=8 first=(0,0) done=1",
                     n_hs, got_x[0], got_y[0], n_done);
        end
    endtask

`ifdef MANDEL_SCHED_ABORT_EN
    task automatic test_abort();
        int fd;
        iter_mode = 0;
        pix_ready = 1'b0;
        start_frame(10);
        wait_valid("ab_wait0");
        pix_ready = 1'b1;
        @(negedge clk);
        pix_ready = 1'b0;
        wait_valid("ab_wait1");
        abort     = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        pix_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || frame_done !== 1'b0 || pix_x !== 2'd0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b v=%b fd=%b x=%0d want 0 0 0 0",
                     busy, pix_valid, frame_done, pix_x);
        end
        fd = 0;
        for (int c = 0; c < 6; c++) begin
            if (frame_done) fd++;
            @(negedge clk);
        end
        checks++;
        if (fd !== 0) begin
            errors++;
            $display("FAIL abort_nodone: frame_done pulses %0d want 0", fd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_classify();
        test_backpressure();
        test_ignored();
        test_mid_reset();
`ifdef MANDEL_SCHED_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
